// File: rtl/mul_operand_packer_pkg.sv
// Shared constants for the multiplier-array operand packer: vector geometry, b-operand slot
// offset, the supported operand widths and a constant-safe ceiling log2.
package mul_operand_packer_pkg;

  localparam int unsigned Lanes   = 36;
  localparam int unsigned SlotW   = 6;
  localparam int unsigned BOfs    = 3;
  localparam int unsigned OpW2Bit = 2;
  localparam int unsigned OpW3Bit = 3;

  // Usable in parameter defaults, unlike a runtime loop over $clog2 in some tools.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    int unsigned v;
    result = 0;
    if (value > 1) begin
      for (v = value - 1; v > 0; v = v >> 1) begin
        result = result + 1;
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/mul_operand_packer.sv
// Packs a serial stream of (a, b) operand pairs into LANES-slot vectors for the multiplier
// array. A fill buffer collects pairs; a separate output buffer holds the presented vector.
module mul_operand_packer
  import mul_operand_packer_pkg::*;
#(
  parameter int unsigned LANES  = Lanes,
  parameter int unsigned SLOT_W = SlotW,
  parameter int unsigned OP_W   = OpW2Bit,
  parameter int unsigned CNT_W  = clog2(LANES + 1)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [OP_W-1:0]           in_a,
  input  logic [OP_W-1:0]           in_b,
  input  logic                      in_last,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [LANES*SLOT_W-1:0]   filterOut,
  output logic [CNT_W-1:0]          out_count,
  output logic                      out_last
);

  localparam int unsigned VecW = LANES * SLOT_W;

  if (OP_W < 1 || OP_W > BOfs || BOfs + OP_W > SLOT_W) begin : g_bad_op_w
    $error("mul_operand_packer: OP_W must be 1..%0d so b fits above a", BOfs);
  end

  logic [VecW-1:0]   fill_q, fill_d;
  logic [CNT_W-1:0]  fill_cnt_q, fill_cnt_d;
  logic              fill_full_q, fill_full_d;
  logic              fill_last_q, fill_last_d;

  logic              out_valid_q;
  logic [VecW-1:0]   out_data_q;
  logic [CNT_W-1:0]  out_count_q;
  logic              out_last_q;

  logic              accept;
  logic              xfer;
  logic [CNT_W-1:0]  base_cnt;
  logic [SLOT_W-1:0] slot_val;

  assign xfer     = fill_full_q && (!out_valid_q || out_ready);
  assign in_ready = reset && (!fill_full_q || xfer);
  assign accept   = in_valid && in_ready;

  // In a transfer cycle the buffer is logically empty, so a new pair lands in slot 0.
  assign base_cnt = xfer ? '0 : fill_cnt_q;

  always_comb begin
    slot_val               = '0;
    slot_val[OP_W-1:0]     = in_a;
    slot_val[BOfs +: OP_W] = in_b;
  end

  for (genvar i = 0; i < LANES; i++) begin : g_slot
    logic slot_we;
    assign slot_we = accept && (base_cnt == CNT_W'(i));
    assign fill_d[i*SLOT_W +: SLOT_W] = slot_we ? slot_val :
                                        xfer    ? '0       : fill_q[i*SLOT_W +: SLOT_W];
  end

  always_comb begin
    fill_cnt_d  = fill_cnt_q;
    fill_full_d = fill_full_q;
    fill_last_d = fill_last_q;
    if (xfer) begin
      fill_cnt_d  = '0;
      fill_full_d = 1'b0;
      fill_last_d = 1'b0;
    end
    if (accept) begin
      fill_cnt_d  = base_cnt + CNT_W'(1);
      fill_full_d = (base_cnt == CNT_W'(LANES - 1)) || in_last;
      fill_last_d = in_last;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fill_q      <= '0;
      fill_cnt_q  <= '0;
      fill_full_q <= 1'b0;
      fill_last_q <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_count_q <= '0;
      out_last_q  <= 1'b0;
    end else begin
      fill_q      <= fill_d;
      fill_cnt_q  <= fill_cnt_d;
      fill_full_q <= fill_full_d;
      fill_last_q <= fill_last_d;
      if (xfer) begin
        out_valid_q <= 1'b1;
        out_data_q  <= fill_q;
        out_count_q <= fill_cnt_q;
        out_last_q  <= fill_last_q;
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign filterOut = out_data_q;
  assign out_count = out_count_q;
  assign out_last  = out_last_q;

endmodule

// File: tb/tb_mul_operand_packer.sv
// Directed bench for mul_operand_packer: single-pair table, full/partial vectors,
// back-to-back streaming, backpressure, mid-vector reset and a 3-bit operand build.
module tb_mul_operand_packer;

  typedef logic [215:0] vec_t;
  typedef struct {
    logic [1:0] a;
    logic [1:0] b;
    logic [5:0] slot;
  } vrec_t;

  logic       clk;
  logic       reset;
  logic       in_valid, in_ready, in_last;
  logic [1:0] in_a, in_b;
  logic       out_valid, out_ready, out_last;
  vec_t       filter_out;
  logic [5:0] out_count;

  logic       in_valid3, in_ready3, in_last3;
  logic [2:0] in_a3, in_b3;
  logic       out_valid3, out_ready3, out_last3;
  vec_t       filter_out3;
  logic [5:0] out_count3;

  int n_vec = 0;
  int n_bad = 0;
  int rdy_drops;

  mul_operand_packer #(.LANES(36), .SLOT_W(6), .OP_W(2), .CNT_W(6)) u_dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .filterOut (filter_out),
    .out_count (out_count),
    .out_last  (out_last)
  );

  mul_operand_packer #(.LANES(36), .SLOT_W(6), .OP_W(3), .CNT_W(6)) u_dut3 (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid3),
    .in_ready  (in_ready3),
    .in_a      (in_a3),
    .in_b      (in_b3),
    .in_last   (in_last3),
    .out_valid (out_valid3),
    .out_ready (out_ready3),
    .filterOut (filter_out3),
    .out_count (out_count3),
    .out_last  (out_last3)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish, want finish within 200000 time units");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b, want %b", name, act, exp);
    end
  endtask

  task automatic chkn(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic chkv(input string name, input vec_t act, input vec_t exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  // Pair k of a run: a = k[1:0], b = k[3:2].
  function automatic vec_t exp_vec(input int n, input int seed);
    vec_t v;
    v = '0;
    for (int i = 0; i < n; i++) begin
      int k;
      k = seed + i;
      v[i*6 +: 6] = {1'b0, k[3:2], 1'b0, k[1:0]};
    end
    return v;
  endfunction

  task automatic drive_pairs(input int n, input int seed, input bit last_at_end);
    for (int i = 0; i < n; i++) begin
      int k;
      k = seed + i;
      in_valid = 1'b1;
      in_a     = k[1:0];
      in_b     = k[3:2];
      in_last  = last_at_end && (i == n - 1);
      if (!in_ready) rdy_drops++;
      step();
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  initial begin
    vrec_t tbl [7];
    vec_t  e;
    int    seen;

    tbl[0] = '{a: 2'b01, b: 2'b11, slot: 6'h19};
    tbl[1] = '{a: 2'b11, b: 2'b00, slot: 6'h03};
    tbl[2] = '{a: 2'b00, b: 2'b11, slot: 6'h18};
    tbl[3] = '{a: 2'b10, b: 2'b01, slot: 6'h0A};
    tbl[4] = '{a: 2'b11, b: 2'b11, slot: 6'h1B};
    tbl[5] = '{a: 2'b01, b: 2'b10, slot: 6'h11};
    tbl[6] = '{a: 2'b00, b: 2'b00, slot: 6'h00};

    reset = 1'b0;
    in_valid = 1'b0; in_a = '0; in_b = '0; in_last = 1'b0; out_ready = 1'b1;
    in_valid3 = 1'b0; in_a3 = '0; in_b3 = '0; in_last3 = 1'b0; out_ready3 = 1'b1;

    // Reset state.
    #12;
    chk1("rst_in_ready", in_ready, 1'b0);
    chk1("rst_out_valid", out_valid, 1'b0);
    chkv("rst_data", filter_out, '0);
    chkn("rst_count", int'(out_count), 0);
    chk1("rst_last", out_last, 1'b0);
    chk1("rst3_out_valid", out_valid3, 1'b0);
    reset = 1'b1;
    #1;
    chk1("rel_in_ready", in_ready, 1'b1);
    step();

    // Single-pair vectors from the table.
    foreach (tbl[j]) begin
      in_valid = 1'b1; in_a = tbl[j].a; in_b = tbl[j].b; in_last = 1'b1;
      step();
      in_valid = 1'b0; in_last = 1'b0;
      chk1("one_valid_t1", out_valid, 1'b0);
      step();
      e = '0;
      e[5:0] = tbl[j].slot;
      chk1("one_valid_t2", out_valid, 1'b1);
      chkv("one_data", filter_out, e);
      chkn("one_count", int'(out_count), 1);
      chk1("one_last", out_last, 1'b1);
      step();
      chk1("one_release", out_valid, 1'b0);
    end

    // Full vector, a = i, b = ~i.
    rdy_drops = 0;
    e = '0;
    for (int i = 0; i < 36; i++) begin
      logic [1:0] ai;
      ai = i[1:0];
      in_valid = 1'b1; in_a = ai; in_b = ~ai;
      e[i*6 +: 6] = {1'b0, ~ai, 1'b0, ai};
      if (!in_ready) rdy_drops++;
      step();
    end
    in_valid = 1'b0;
    chk1("full_valid_t1", out_valid, 1'b0);
    if (!in_ready) rdy_drops++;
    step();
    chk1("full_valid_t2", out_valid, 1'b1);
    chkv("full_data", filter_out, e);
    chkn("full_count", int'(out_count), 36);
    chk1("full_last", out_last, 1'b0);
    chkn("full_rdy_drops", rdy_drops, 0);
    step();

    // in_last on the final slot.
    drive_pairs(36, 9, 1'b1);
    step();
    chkv("last35_data", filter_out, exp_vec(36, 9));
    chkn("last35_count", int'(out_count), 36);
    chk1("last35_last", out_last, 1'b1);
    step();

    // Partial vector: unused slots stay zero.
    drive_pairs(3, 20, 1'b1);
    step();
    chk1("part_valid", out_valid, 1'b1);
    chkv("part_data", filter_out, exp_vec(3, 20));
    chkn("part_count", int'(out_count), 3);
    chk1("part_last", out_last, 1'b1);
    step();

    // 72 back-to-back pairs: vectors visible 2 edges after pairs 35 and 71.
    rdy_drops = 0;
    seen = 0;
    for (int k = 0; k < 74; k++) begin
      if (out_valid) begin
        chkn("b2b_cycle", k, (seen == 0) ? 37 : 73);
        chkv("b2b_data", filter_out, exp_vec(36, 36 * seen));
        chkn("b2b_count", int'(out_count), 36);
        seen++;
      end
      if (k < 72) begin
        in_valid = 1'b1; in_a = k[1:0]; in_b = k[3:2];
        if (!in_ready) rdy_drops++;
      end else begin
        in_valid = 1'b0;
      end
      step();
    end
    chkn("b2b_vectors", seen, 2);
    chkn("b2b_rdy_drops", rdy_drops, 0);

    // Backpressure: output held, second vector fills, then input stalls.
    out_ready = 1'b0;
    rdy_drops = 0;
    drive_pairs(72, 100, 1'b0);
    chkn("bp_rdy_drops", rdy_drops, 0);
    chk1("bp_in_ready", in_ready, 1'b0);
    chk1("bp_valid", out_valid, 1'b1);
    chkv("bp_data0", filter_out, exp_vec(36, 100));
    repeat (3) step();
    chk1("bp_hold_in_ready", in_ready, 1'b0);
    chkv("bp_hold_data", filter_out, exp_vec(36, 100));
    chkn("bp_hold_count", int'(out_count), 36);
    out_ready = 1'b1;
    #1;
    chk1("bp_xfer_ready", in_ready, 1'b1);
    step();
    out_ready = 1'b0;
    chk1("bp_valid2", out_valid, 1'b1);
    chkv("bp_data1", filter_out, exp_vec(36, 136));
    chk1("bp_ready_back", in_ready, 1'b1);
    out_ready = 1'b1;
    step();
    chk1("bp_release", out_valid, 1'b0);

    // Mid-vector reset with a vector sitting on the output.
    out_ready = 1'b0;
    in_valid = 1'b1; in_a = 2'b01; in_b = 2'b10; in_last = 1'b1;
    step();
    in_valid = 1'b0; in_last = 1'b0;
    step();
    chk1("mr_pre_valid", out_valid, 1'b1);
    drive_pairs(10, 50, 1'b0);
    #3 reset = 1'b0;
    #1;
    chk1("mr_valid", out_valid, 1'b0);
    chkv("mr_data", filter_out, '0);
    chkn("mr_count", int'(out_count), 0);
    chk1("mr_in_ready", in_ready, 1'b0);
    #3 reset = 1'b1;
    #1;
    chk1("mr_rel_ready", in_ready, 1'b1);
    out_ready = 1'b1;
    step();
    drive_pairs(36, 5, 1'b0);
    step();
    chk1("mr_new_valid", out_valid, 1'b1);
    chkv("mr_new_data", filter_out, exp_vec(36, 5));
    chkn("mr_new_count", int'(out_count), 36);
    chk1("mr_new_last", out_last, 1'b0);
    step();

    // 3-bit operand build.
    in_valid3 = 1'b1; in_a3 = 3'b101; in_b3 = 3'b011; in_last3 = 1'b1;
    step();
    in_valid3 = 1'b0; in_last3 = 1'b0;
    step();
    e = '0;
    e[5:0] = 6'b011101;
    chk1("op3_valid", out_valid3, 1'b1);
    chkv("op3_data", filter_out3, e);
    chkn("op3_count", int'(out_count3), 1);
    chk1("op3_last", out_last3, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/mul_operand_packer.md
Name: mul_operand_packer

Overview:
- Producer side of the multiplier array's packed-operand interface.
- Accepts a serial valid/ready stream of operand pairs (a, b) and packs them into a LANES-slot vector of SLOT_W-bit slots: a at slot offset 0, b at slot offset 3, all other bits zero.
- Presents each completed vector to the multiplier array with a valid/ready handshake.
- Two register stages (fill buffer, output buffer) give zero-bubble back-to-back vectors.

Parameters:
LANES, 36, number of operand slots per vector
SLOT_W, 6, bits per slot
OP_W, 2, operand width; legal 1..3 (b must fit in bits [5:3])
CNT_W, 6, width of lane counters; must hold the value LANES (clog2(LANES+1))

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-low reset
in_valid  input  1  operand pair present
in_ready  output  1  pair accepted when in_valid && in_ready
in_a  input  OP_W  first operand
in_b  input  OP_W  second operand
in_last  input  1  closes the current vector after this pair (partial vector)
out_valid  output  1  packed vector available
out_ready  input  1  consumer accepts the vector
filterOut  output  LANES*SLOT_W  packed vector; slot i = filterOut[i*SLOT_W +: SLOT_W]
out_count  output  CNT_W  number of populated slots (1..LANES)
out_last  output  1  vector was closed by in_last

Behaviour:
- Reset (reset=0, asynchronous): fill buffer zeroed, fill_cnt=0, fill_full=0, out_valid=0, filterOut=0, out_count=0, out_last=0. A partial vector is discarded. in_ready is 0 while reset is asserted and 1 on the first cycle after release.
- Accept: on in_valid && in_ready:
  - write slot fill_cnt: bits [OP_W-1:0]=in_a, bits [3+OP_W-1:3]=in_b, others 0;
  - fill_cnt increments.
  - If fill_cnt==LANES-1 or in_last=1, set fill_full=1 and latch fill_last=in_last.
- Transfer condition: xfer = fill_full && (!out_valid || out_ready). On xfer:
  - filterOut takes the fill buffer; out_count takes the populated-slot count; out_last takes fill_last; out_valid=1;
  - fill buffer zeroed, fill_cnt=0, fill_full=0.
- in_ready = !fill_full || xfer (combinational).
  - A pair accepted in a transfer cycle writes slot 0 of the freshly cleared buffer.
  - This slot-0 write takes priority over the clear.
- Output release: if out_valid && out_ready && !xfer, out_valid goes to 0. filterOut and out_count hold their last values.
- Stability: while out_valid=1 and out_ready=0, filterOut, out_count and out_last are held constant.
- Latency: the pair completing a vector is accepted at cycle t. fill_full=1 at t+1, xfer at t+1 if the output is free, out_valid=1 at t+2.
- Throughput: sustained one pair per cycle with out_ready held at 1; no bubbles between vectors.
- Backpressure: the fill buffer stalls input only when it is full and the output is held. At most one complete vector plus one filled buffer are in flight.
- A vector always holds at least 1 pair; an empty vector is never emitted. in_last on slot LANES-1 yields out_count=LANES, out_last=1.
- in_a and in_b are don't-care when in_valid=0. Unused slots are guaranteed zero.

Decomposition:
- Shared package:
  - LANES, SLOT_W, B_OFS=3;
  - OP_W choices 2 and 3 (for the 2-bit and 3-bit multiplier groups);
  - a clog2 function.
- No sub-module. The slot write is a generate loop with per-slot write-enable decode from fill_cnt.

Test Plan:
- Single pair a=2'b01, b=2'b11, in_last=1, out_ready=1 → out_valid at t+2; filterOut[5:0]=6'h19; remaining bits 0; out_count=1; out_last=1.
- 36 pairs, pair i with a=i[1:0], b=~i[1:0], out_ready=1, no in_last → one vector with out_count=36, out_last=0; every slot is correct; in_ready stays 1 throughout.
- 72 continuous pairs with out_ready=1 → two vectors; out_valid is high 2 cycles after each 36th pair; no in_ready drop.
- out_ready=0 after the first vector → in_ready falls after the second vector fills (72 pairs accepted); filterOut is stable; out_ready=1 for one cycle → the second vector appears next cycle and in_ready returns.
- Reset pulsed low mid-vector after 10 pairs → outputs 0 immediately (asynchronous); after release, 36 new pairs produce a vector with no remnants of the old pairs.
- OP_W=3 build: a=3'b101, b=3'b011 → slot 6'b011101; other slots 0; out_count=1.
